// File: rtl/bus_wait_ctrl_if.sv
// rtl/bus_wait_ctrl_if.sv - CPU-side and device-side bus bundle for the wait-state controller
interface bus_wait_ctrl_if;
    logic [21:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic        cpu_mem_io;
    logic        cpu_halt;
    logic        cpu_dma_ack;
    logic [7:0]  cpu_data_in;
    logic        cpu_wait;
    logic        dev_req;
    logic        dev_we;
    logic [21:0] dev_addr;
    logic [7:0]  dev_wdata;
    logic [7:0]  dev_rdata;
    logic        dev_ack;
    logic        err_timeout;
    logic        err_proto;
    logic        err_clr;

    modport slave (
        input  cpu_addr, cpu_data_out, cpu_rd_n, cpu_wr_n, cpu_mem_io,
        input  cpu_halt, cpu_dma_ack, dev_rdata, dev_ack, err_clr,
        output cpu_data_in, cpu_wait, dev_req, dev_we, dev_addr, dev_wdata,
        output err_timeout, err_proto
    );

    modport master (
        output cpu_addr, cpu_data_out, cpu_rd_n, cpu_wr_n, cpu_mem_io,
        output cpu_halt, cpu_dma_ack, dev_rdata, dev_ack, err_clr,
        input  cpu_data_in, cpu_wait, dev_req, dev_we, dev_addr, dev_wdata,
        input  err_timeout, err_proto
    );
endinterface

// File: rtl/bus_wait_ctrl.sv
// rtl/bus_wait_ctrl.sv - region-decoded wait-state insertion and IO handshake with timeout
module bus_wait_ctrl #(
    parameter int ROM_WAIT   = 2,
    parameter int RAM_WAIT   = 0,
    parameter int IO_TIMEOUT = 64
) (
    input logic              clk,
    input logic              arst,
    bus_wait_ctrl_if.slave   bus
);
    localparam logic [7:0] ROM_W  = 8'(ROM_WAIT);
    localparam logic [7:0] RAM_W  = 8'(RAM_WAIT);
    localparam logic [7:0] IO_TO  = 8'(IO_TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT_CNT, IO_HS, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       prev_rd_n, prev_wr_n;
    logic       armed;
    logic       rd_fall, wr_fall, both_low, strobes_high, bus_free, abort;
    logic       start, proto_evt, latch, capture, timeout_evt, dev_req_nxt;
    logic [7:0] mem_wait;

    assign rd_fall      = armed & prev_rd_n & ~bus.cpu_rd_n;
    assign wr_fall      = armed & prev_wr_n & ~bus.cpu_wr_n;
    assign both_low     = ~bus.cpu_rd_n & ~bus.cpu_wr_n;
    assign strobes_high = bus.cpu_rd_n & bus.cpu_wr_n;
    assign bus_free     = ~bus.cpu_halt & ~bus.cpu_dma_ack;
    assign abort        = strobes_high | ~bus_free;
    assign mem_wait     = (bus.cpu_addr < 22'h008000) ? ROM_W : RAM_W;

    // A strobe held low through reset release is not a start: armed gates edge detection for one cycle.
    assign start     = (state == IDLE) & bus_free & (rd_fall ^ wr_fall) & ~both_low;
    assign proto_evt = (state == IDLE) & bus_free & (rd_fall | wr_fall) & both_low;

    assign bus.cpu_wait = (start & (~bus.cpu_mem_io | (mem_wait != 8'd0)))
                        | (state == WAIT_CNT) | (state == IO_HS);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        dev_req_nxt = bus.dev_req;
        latch       = 1'b0;
        capture     = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    latch       = 1'b1;
                    dev_req_nxt = 1'b1;
                    if (!bus.cpu_mem_io) begin
                        state_nxt = IO_HS;
                        cnt_nxt   = IO_TO;
                    end else begin
                        cnt_nxt   = mem_wait;
                        state_nxt = (mem_wait == 8'd0) ? DONE : WAIT_CNT;
                    end
                end
            end
            WAIT_CNT: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    dev_req_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state_nxt   = DONE;
                        dev_req_nxt = 1'b0;
                        capture     = ~bus.dev_we;
                    end
                end
            end
            IO_HS: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    dev_req_nxt = 1'b0;
                end else if (bus.dev_ack) begin
                    state_nxt   = DONE;
                    dev_req_nxt = 1'b0;
                    capture     = ~bus.dev_we;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state_nxt   = DONE;
                        dev_req_nxt = 1'b0;
                        timeout_evt = 1'b1;
                    end
                end
            end
            DONE: begin
                // dev_req is only still high here for a zero-wait access; its data arrives now.
                dev_req_nxt = 1'b0;
                capture     = bus.dev_req & ~bus.dev_we & bus_free;
                if (abort) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state           <= IDLE;
            cnt             <= 8'd0;
            prev_rd_n       <= 1'b1;
            prev_wr_n       <= 1'b1;
            armed           <= 1'b0;
            bus.cpu_data_in <= 8'h00;
            bus.dev_req     <= 1'b0;
            bus.dev_we      <= 1'b0;
            bus.dev_addr    <= 22'd0;
            bus.dev_wdata   <= 8'h00;
            bus.err_timeout <= 1'b0;
            bus.err_proto   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            prev_rd_n   <= bus.cpu_rd_n;
            prev_wr_n   <= bus.cpu_wr_n;
            armed       <= 1'b1;
            bus.dev_req <= dev_req_nxt;
            if (latch) begin
                bus.dev_addr  <= bus.cpu_addr;
                bus.dev_wdata <= bus.cpu_data_out;
                bus.dev_we    <= wr_fall;
            end
            if (capture)
                bus.cpu_data_in <= bus.dev_rdata;
            else if (timeout_evt && !bus.dev_we)
                bus.cpu_data_in <= 8'hFF;
            bus.err_timeout <= timeout_evt | (bus.err_timeout & ~bus.err_clr);
            bus.err_proto   <= proto_evt | (bus.err_proto & ~bus.err_clr);
        end
    end
endmodule

// File: tb/tb_bus_wait_ctrl.sv
// tb/tb_bus_wait_ctrl.sv - directed checks of bus_wait_ctrl; u_dut_b runs IO_TIMEOUT=4 on mirrored inputs
module tb_bus_wait_ctrl;
    logic clk = 1'b0;
    logic arst;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_wait, n_wait_b, n_req, last_wait, to_b_at, bad_req;

    always #5 clk = ~clk;

    bus_wait_ctrl_if bus ();
    bus_wait_ctrl_if bus_b ();

    assign bus_b.cpu_addr     = bus.cpu_addr;
    assign bus_b.cpu_data_out = bus.cpu_data_out;
    assign bus_b.cpu_rd_n     = bus.cpu_rd_n;
    assign bus_b.cpu_wr_n     = bus.cpu_wr_n;
    assign bus_b.cpu_mem_io   = bus.cpu_mem_io;
    assign bus_b.cpu_halt     = bus.cpu_halt;
    assign bus_b.cpu_dma_ack  = bus.cpu_dma_ack;
    assign bus_b.dev_rdata    = bus.dev_rdata;
    assign bus_b.dev_ack      = bus.dev_ack;
    assign bus_b.err_clr      = bus.err_clr;

    bus_wait_ctrl u_dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus.slave)
    );

    bus_wait_ctrl #(.IO_TIMEOUT(4)) u_dut_b (
        .clk  (clk),
        .arst (arst),
        .bus  (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
    endtask

    // Cycle 0 is the start cycle; dev_ack is raised only in cycle ack_at.
    task automatic access(input logic mem_io, input logic [21:0] addr, input logic wr,
                          input logic [7:0] wd, input int ncyc, input int ack_at);
        n_wait = 0; n_wait_b = 0; n_req = 0; last_wait = -1; to_b_at = -1; bad_req = 0;
        bus.cpu_mem_io   = mem_io;
        bus.cpu_addr     = addr;
        bus.cpu_data_out = wd;
        if (wr) bus.cpu_wr_n = 1'b0;
        else    bus.cpu_rd_n = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            bus.dev_ack = (i == ack_at);
            @(negedge clk);
            if (bus.cpu_wait) begin n_wait++; last_wait = i; end
            if (bus_b.cpu_wait) n_wait_b++;
            if (bus.dev_req) begin
                n_req++;
                if (bus.dev_addr !== addr || bus.dev_we !== wr || (wr && bus.dev_wdata !== wd))
                    bad_req++;
            end
            if (bus_b.err_timeout && to_b_at < 0) to_b_at = i;
            tick();
        end
        bus.dev_ack  = 1'b0;
        bus.cpu_rd_n = 1'b1;
        bus.cpu_wr_n = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        arst = 1'b1;
        bus.cpu_addr = 22'd0; bus.cpu_data_out = 8'h00;
        bus.cpu_rd_n = 1'b1;  bus.cpu_wr_n = 1'b1; bus.cpu_mem_io = 1'b1;
        bus.cpu_halt = 1'b0;  bus.cpu_dma_ack = 1'b0;
        bus.dev_rdata = 8'h00; bus.dev_ack = 1'b0; bus.err_clr = 1'b0;
        tick(); tick();
        check("rst_data_in", 32'(bus.cpu_data_in), 32'h00);
        check("rst_dev_req", 32'(bus.dev_req), 32'h0);
        check("rst_dev_addr", 32'(bus.dev_addr), 32'h0);
        check("rst_errs", {30'd0, bus.err_timeout, bus.err_proto}, 32'h0);
        arst = 1'b0;
        tick(); tick();

        // ROM read, 2 wait states
        bus.dev_rdata = 8'h5A;
        access(1'b1, 22'h000100, 1'b0, 8'h00, 6, -1);
        check("rom_rd_wait_cycles", 32'(n_wait), 32'd3);
        check("rom_rd_req_cycles", 32'(n_req), 32'd2);
        check("rom_rd_req_fields", 32'(bad_req), 32'd0);
        check("rom_rd_data", 32'(bus.cpu_data_in), 32'h5A);

        // RAM write, zero wait
        bus.dev_rdata = 8'h11;
        access(1'b1, 22'h123456, 1'b1, 8'hC3, 4, -1);
        check("ram_wr_wait_cycles", 32'(n_wait), 32'd0);
        check("ram_wr_req_cycles", 32'(n_req), 32'd1);
        check("ram_wr_req_fields", 32'(bad_req), 32'd0);
        check("ram_wr_keeps_data", 32'(bus.cpu_data_in), 32'h5A);

        // RAM read, zero wait
        bus.dev_rdata = 8'h96;
        access(1'b1, 22'h200000, 1'b0, 8'h00, 4, -1);
        check("ram_rd_wait_cycles", 32'(n_wait), 32'd0);
        check("ram_rd_data", 32'(bus.cpu_data_in), 32'h96);

        // IO read acked in cycle 5; u_dut_b times out after 4 IO_HS cycles
        bus.dev_rdata = 8'h77;
        access(1'b0, 22'h000042, 1'b0, 8'h00, 8, 5);
        check("io_rd_wait_cycles", 32'(n_wait), 32'd6);
        check("io_rd_last_wait", 32'(last_wait), 32'd5);
        check("io_rd_req_cycles", 32'(n_req), 32'd5);
        check("io_rd_data", 32'(bus.cpu_data_in), 32'h77);
        check("io_rd_no_timeout", 32'(bus.err_timeout), 32'h0);
        check("io_to_wait_cycles", 32'(n_wait_b), 32'd5);
        check("io_to_flag_cycle", 32'(to_b_at), 32'd5);
        check("io_to_data_ff", 32'(bus_b.cpu_data_in), 32'hFF);
        check("io_to_flag_sticky", 32'(bus_b.err_timeout), 32'h1);
        pulse_clr();
        check("io_to_cleared", 32'(bus_b.err_timeout), 32'h0);

        // ack in the same cycle the timeout would fire
        bus.dev_rdata = 8'h3C;
        access(1'b0, 22'h000043, 1'b0, 8'h00, 6, 4);
        check("ack_vs_to_flag", 32'(bus_b.err_timeout), 32'h0);
        check("ack_vs_to_data", 32'(bus_b.cpu_data_in), 32'h3C);

        // both strobes falling together
        access(1'b1, 22'h000200, 1'b0, 8'h00, 0, -1);
        bus.cpu_rd_n = 1'b0; bus.cpu_wr_n = 1'b0;
        n_req = 0; n_wait = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.dev_req) n_req++;
            if (bus.cpu_wait) n_wait++;
            tick();
        end
        check("proto_req_cycles", 32'(n_req), 32'd0);
        check("proto_wait_cycles", 32'(n_wait), 32'd0);
        check("proto_flag", 32'(bus.err_proto), 32'h1);
        bus.cpu_rd_n = 1'b1; bus.cpu_wr_n = 1'b1;
        tick();
        pulse_clr();
        check("proto_cleared", 32'(bus.err_proto), 32'h0);

        // dma_ack raised in the first WAIT_CNT cycle of a ROM read
        bus.dev_rdata = 8'hEE;
        bus.cpu_mem_io = 1'b1; bus.cpu_addr = 22'h000080; bus.cpu_rd_n = 1'b0;
        tick();
        bus.cpu_dma_ack = 1'b1;
        @(negedge clk);
        check("dma_req_before", 32'(bus.dev_req), 32'h1);
        tick();
        @(negedge clk);
        check("dma_req_dropped", 32'(bus.dev_req), 32'h0);
        check("dma_wait_dropped", 32'(bus.cpu_wait), 32'h0);
        tick();
        bus.cpu_dma_ack = 1'b0; bus.cpu_rd_n = 1'b1;
        tick(); tick(); tick();
        check("dma_data_kept", 32'(bus.cpu_data_in), 32'h3C);

        // reset during IO_HS with the read strobe held low afterwards
        bus.cpu_mem_io = 1'b0; bus.cpu_addr = 22'h000011; bus.cpu_rd_n = 1'b0;
        tick();
        arst = 1'b1;
        @(negedge clk);
        check("rst_mid_req_before", 32'(bus.dev_req), 32'h1);
        tick();
        @(negedge clk);
        check("rst_mid_req", 32'(bus.dev_req), 32'h0);
        check("rst_mid_addr", 32'(bus.dev_addr), 32'h0);
        check("rst_mid_data", 32'(bus.cpu_data_in), 32'h00);
        check("rst_mid_errs", {30'd0, bus.err_timeout, bus.err_proto}, 32'h0);
        tick();
        arst = 1'b0;
        n_req = 0; n_wait = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.dev_req) n_req++;
            if (bus.cpu_wait) n_wait++;
            tick();
        end
        check("held_strobe_no_req", 32'(n_req), 32'd0);
        check("held_strobe_no_wait", 32'(n_wait), 32'd0);
        bus.cpu_rd_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bus_wait_ctrl.md
BUS_WAIT_CTRL -- requirements
Module: bus_wait_ctrl

Interface
REQ-001 Parameter ROM_WAIT, default 2, wait states for ROM region accesses (0-15).
REQ-002 Parameter RAM_WAIT, default 0, wait states for RAM region accesses (0-15).
REQ-003 Parameter IO_TIMEOUT, default 64, max cycles to wait for dev_ack on IO accesses (2-255).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock, same clock as the CPU core.
REQ-006 arst  in  1  synchronous active-high reset.
REQ-007 cpu_addr  in  22  CPU address bus.
REQ-008 cpu_data_out  in  8  CPU write data.
REQ-009 cpu_rd_n / cpu_wr_n  in  1 each  active-low CPU strobes.
REQ-010 cpu_mem_io  in  1  1 = memory space, 0 = IO space.
REQ-011 cpu_halt / cpu_dma_ack  in  1 each  CPU bus is tristated when either is 1.
REQ-012 cpu_data_in  out  8  read data returned to the CPU.
REQ-013 cpu_wait  out  1  active-high stall request to the CPU sequencer.
REQ-014 dev_req / dev_we  out  1 each  downstream request and write qualifier.
REQ-015 dev_addr  out  22; dev_wdata  out  8; dev_rdata  in  8; dev_ack  in  1  downstream handshake.
REQ-016 err_timeout / err_proto  out  1 each  sticky error flags; err_clr  in  1  clears both.

Function
REQ-017 Region decode: IO = cpu_mem_io 0; ROM = cpu_mem_io 1 and cpu_addr < 22'h008000; RAM = all other memory addresses.
REQ-018 Access start: registered previous-strobe values; a start is a 1->0 transition of exactly one of cpu_rd_n/cpu_wr_n while cpu_halt=0 and cpu_dma_ack=0.
REQ-019 Both strobes low in the same cycle: no access starts, err_proto is set, and the FSM stays in IDLE.
REQ-020 States: IDLE, WAIT_CNT, IO_HS, DONE.
REQ-021 IDLE: on a start, latch address, write data, and direction into dev_addr, dev_wdata, and dev_we; memory accesses go to WAIT_CNT with cnt=ROM_WAIT/RAM_WAIT; IO accesses go to IO_HS with cnt=IO_TIMEOUT.
REQ-022 Memory access with wait count 0: go directly to DONE; cpu_wait is never asserted.
REQ-023 WAIT_CNT: dev_req=1; cnt decrements each cycle; leave for DONE in the cycle cnt==1, capturing dev_rdata on reads.
REQ-024 Memory access with wait count N: dev_req is high for exactly N cycles.
REQ-025 IO_HS: dev_req=1 until dev_ack=1 is sampled; then capture dev_rdata on reads and go to DONE.
REQ-026 IO_HS timeout: cnt decrements each cycle; if cnt reaches 0 without dev_ack, set err_timeout, load cpu_data_in=8'hFF on reads, and go to DONE.
REQ-027 dev_ack and timeout in the same cycle: dev_ack wins, and err_timeout is not set.
REQ-028 cpu_wait is combinational: 1 in a start cycle when the access is IO or its wait count > 0; 1 in WAIT_CNT and IO_HS; 0 in IDLE (non-start cycles) and DONE.
REQ-029 DONE: dev_req=0; return to IDLE only when both strobes are high; a new start is not accepted until then.
REQ-030 Strobe released (both strobes high) in WAIT_CNT or IO_HS: abort; dev_req drops next cycle; go to IDLE; cpu_data_in is unchanged.
REQ-031 cpu_halt or cpu_dma_ack going to 1 in any non-IDLE state: same abort as REQ-030.
REQ-032 cpu_data_in holds the last captured value until the next read completes; writes never change it.
REQ-033 dev_addr, dev_wdata, and dev_we are stable throughout the whole dev_req assertion.
REQ-034 err_timeout and err_proto are sticky until err_clr=1; err_clr=1 clears both on the next edge.
REQ-035 A set event coincident with err_clr=1 leaves the flag set.

Reset
REQ-036 arst=1 at a clock edge: FSM=IDLE, cnt=0, cpu_data_in=8'h00, dev_req=0, dev_we=0, dev_addr=0, dev_wdata=0, err_timeout=0, err_proto=0, previous-strobe registers=1.
REQ-037 Reset asserted mid-access: the access is dropped, dev_req=0 the cycle after the edge, and no error flag is set.
REQ-038 After reset is released, a strobe already held low does not count as a start; a 1->0 transition is required.

Verification
REQ-039 ROM read at 22'h000100, ROM_WAIT=2, dev_rdata=8'h5A -> cpu_wait high for 3 cycles, dev_req high for 2 cycles, cpu_data_in=8'h5A.
REQ-040 RAM write at 22'h123456 with data 8'hC3, RAM_WAIT=0 -> cpu_wait never high; dev_req pulses 1 cycle with dev_we=1 and dev_wdata=8'hC3.
REQ-041 IO read with dev_ack after 5 cycles, dev_rdata=8'h77 -> cpu_wait high until the ack cycle; cpu_data_in=8'h77; err_timeout=0.
REQ-042 IO read with no ack, IO_TIMEOUT=4 -> err_timeout=1 after 4 cycles in IO_HS; cpu_data_in=8'hFF; err_clr then clears it.
REQ-043 Both strobes falling together -> err_proto=1 and dev_req stays 0; cpu_dma_ack=1 mid-WAIT_CNT -> abort, dev_req=0 next cycle.
REQ-044 arst=1 during IO_HS -> all outputs at reset values next cycle; a held-low strobe after release starts no access.
